// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
//   LEGV8_NOP     : encoding of the architectural NOP, used for IF/ID bubbles
//   PC_W          : storage width of the PC field inside the IF/ID record
//   if_id_t       : IF/ID pipeline record {pc, instr, valid}
//   IF_ID_BUBBLE  : reset / flush value of the IF/ID record
//   fetch_state_e : fetch sequencing FSM states {BOOT, RUN}
//   misaligned()  : true when a redirect target is not word aligned
package fetch_pkg;

  localparam logic [31:0] LEGV8_NOP = 32'hD503_201F;
  localparam int unsigned PC_W = 64;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: LEGV8_NOP, valid: 1'b0};

  typedef enum logic [0:0] {
    BOOT,
    RUN
  } fetch_state_e;

  function automatic logic misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its environment (hazard unit, MEM stage,
// instruction memory, decode).
//   master : environment side; drives PCWrite/DWrite/PCSrc/PCBranch/imem_instr
//   slave  : fetch stage side; drives imem_addr, IF_ID_*, misalign_err
//            (and stall_cnt/flush_cnt when FETCH_PERF_CNT_EN is defined)
interface fetch_stage_if #(
  parameter int unsigned N = 64
);

  logic         PCWrite;
  logic         DWrite;
  logic         PCSrc;
  logic [N-1:0] PCBranch;
  logic [31:0]  imem_instr;
  logic [N-1:0] imem_addr;
  logic [N-1:0] IF_ID_pc;
  logic [31:0]  IF_ID_instr;
  logic         IF_ID_valid;
  logic         misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]  stall_cnt;
  logic [31:0]  flush_cnt;

  modport master (
    output PCWrite, DWrite, PCSrc, PCBranch, imem_instr,
    input  imem_addr, IF_ID_pc, IF_ID_instr, IF_ID_valid, misalign_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  PCWrite, DWrite, PCSrc, PCBranch, imem_instr,
    output imem_addr, IF_ID_pc, IF_ID_instr, IF_ID_valid, misalign_err, stall_cnt, flush_cnt
  );
`else
  modport master (
    output PCWrite, DWrite, PCSrc, PCBranch, imem_instr,
    input  imem_addr, IF_ID_pc, IF_ID_instr, IF_ID_valid, misalign_err
  );

  modport slave (
    input  PCWrite, DWrite, PCSrc, PCBranch, imem_instr,
    output imem_addr, IF_ID_pc, IF_ID_instr, IF_ID_valid, misalign_err
  );
`endif

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low; loads the bubble record
//   en    : load d on the next edge
//   flush : load the bubble record on the next edge (wins over en)
//   d     : incoming {pc, instr, valid}
//   q     : registered {pc, instr, valid}
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= IF_ID_BUBBLE;
    end else if (flush) begin
      q <= IF_ID_BUBBLE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 IF stage: PC register, instruction-memory address, IF/ID capture,
// branch redirect/flush, load-use stall, sticky misaligned-target flag.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : fetch_stage_if.slave (control in, imem address/data, IF/ID out)
// Optional: define FETCH_PERF_CNT_EN to add saturating stall_cnt/flush_cnt.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned  N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  bus
);

  fetch_state_e state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic         misalign_q, misalign_d;
  logic         if_id_load;
  logic         if_id_flush;
  if_id_t       if_id_d, if_id_q;

  // State register, PC and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  // Next state, next PC and IF/ID controls; redirect beats stall beats advance.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    misalign_d  = misalign_q;
    if_id_load  = 1'b0;
    if_id_flush = 1'b0;

    unique case (state_q)
      // First cycle after reset: imem data is not yet trustworthy, insert a bubble.
      BOOT: begin
        state_d     = RUN;
        if_id_flush = 1'b1;
      end
      RUN: begin
        if (bus.PCSrc) begin
          if_id_flush = 1'b1;
        end else begin
          if_id_load = bus.DWrite;
        end
      end
      default: state_d = BOOT;
    endcase

    // A redirect is honoured even in BOOT; only RUN advances sequentially.
    if (bus.PCSrc) begin
      pc_d = {bus.PCBranch[N-1:2], 2'b00};
      if (misaligned(bus.PCBranch[1:0])) begin
        misalign_d = 1'b1;
      end
    end else if (state_q == RUN && bus.PCWrite) begin
      pc_d = pc_q + N'(4);
    end
  end

  always_comb begin
    if_id_d       = IF_ID_BUBBLE;
    if_id_d.pc    = PC_W'(pc_q);
    if_id_d.instr = bus.imem_instr;
    if_id_d.valid = 1'b1;
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .en    (if_id_load),
    .flush (if_id_flush),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign bus.imem_addr    = pc_q;
  assign bus.IF_ID_pc     = if_id_q.pc[N-1:0];
  assign bus.IF_ID_instr  = if_id_q.instr;
  assign bus.IF_ID_valid  = if_id_q.valid;
  assign bus.misalign_err = misalign_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters, RUN cycles only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (state_q == RUN) begin
      if (bus.PCSrc && flush_cnt_q != 32'hFFFF_FFFF) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
      if (!bus.PCSrc && !bus.PCWrite && stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule
